// File: rtl/mem_port_arbiter.sv
// Shares one single-ported, variable-latency memory between the core's
// instruction-fetch port and its data port. Each access is granted in IDLE,
// held on the memory port through BUSY until mack, then answered with a
// one-cycle ready pulse in RESP. Data wins contention unless it has already
// taken FAIR_LIMIT consecutive grants while a fetch was waiting.
module mem_port_arbiter #(
    parameter int unsigned FAIR_LIMIT = 4
) (
    input  logic        clk,
    input  logic        reset,

    // Instruction-fetch port
    input  logic        ireq,
    input  logic [31:0] iaddr,
    output logic [31:0] irdata,
    output logic        iready,

    // Data (load/store) port
    input  logic        dreq,
    input  logic        dwe,
    input  logic [31:0] daddr,
    input  logic [31:0] dwdata,
    output logic [31:0] drdata,
    output logic        dready,

    // Unified memory port
    output logic        mreq,
    output logic        mwe,
    output logic [31:0] maddr,
    output logic [31:0] mwdata,
    input  logic [31:0] mrdata,
    input  logic        mack
);

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned CW = 4;

    localparam logic [CW-1:0] FAIR_MAX = CW'(FAIR_LIMIT);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    state_e          state_q,      state_d;
    logic [CW-1:0]   fair_cnt_q,   fair_cnt_d;
    logic            win_data_q,   win_data_d;

    // Holding registers for the granted access
    logic [AW-1:0]   hold_addr_q,  hold_addr_d;
    logic            hold_we_q,    hold_we_d;
    logic [DW-1:0]   hold_wdata_q, hold_wdata_d;

    // Registered outputs
    logic            mreq_q,       mreq_d;
    logic            mwe_q,        mwe_d;
    logic [AW-1:0]   maddr_q,      maddr_d;
    logic [DW-1:0]   mwdata_q,     mwdata_d;
    logic            iready_q,     iready_d;
    logic            dready_q,     dready_d;
    logic [DW-1:0]   irdata_q,     irdata_d;
    logic [DW-1:0]   drdata_q,     drdata_d;

    logic            grant_data;

    // Next-state, arbitration, capture and registered-output values
    always_comb begin
        state_d      = state_q;
        fair_cnt_d   = fair_cnt_q;
        win_data_d   = win_data_q;
        hold_addr_d  = hold_addr_q;
        hold_we_d    = hold_we_q;
        hold_wdata_d = hold_wdata_q;
        irdata_d     = irdata_q;
        drdata_d     = drdata_q;
        grant_data   = 1'b0;
        mreq_d       = 1'b0;
        mwe_d        = 1'b0;
        maddr_d      = '0;
        mwdata_d     = '0;
        iready_d     = 1'b0;
        dready_d     = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (ireq || dreq) begin
                    // Data wins unless a waiting fetch has hit its fairness limit
                    grant_data = dreq && !(ireq && (fair_cnt_q >= FAIR_MAX));
                    win_data_d = grant_data;
                    state_d    = ST_BUSY;
                    if (grant_data) begin
                        hold_addr_d  = daddr;
                        hold_we_d    = dwe;
                        hold_wdata_d = dwdata;
                        if (ireq) begin
                            fair_cnt_d = (fair_cnt_q >= FAIR_MAX) ? FAIR_MAX
                                                                  : fair_cnt_q + CW'(1);
                        end else begin
                            fair_cnt_d = '0;
                        end
                    end else begin
                        hold_addr_d  = iaddr;
                        hold_we_d    = 1'b0;
                        hold_wdata_d = '0;
                        fair_cnt_d   = '0;
                    end
                end
            end
            ST_BUSY: begin
                if (mack) begin
                    state_d = ST_RESP;
                    if (win_data_q) begin
                        drdata_d = mrdata;
                    end else begin
                        irdata_d = mrdata;
                    end
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Memory port driven from the holding registers only while in BUSY
        if (state_d == ST_BUSY) begin
            mreq_d   = 1'b1;
            mwe_d    = hold_we_d;
            maddr_d  = hold_addr_d;
            mwdata_d = hold_wdata_d;
        end

        // Winner's ready pulses for the single RESP cycle
        if (state_d == ST_RESP) begin
            iready_d = !win_data_d;
            dready_d = win_data_d;
        end
    end

    // State and output registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            fair_cnt_q   <= '0;
            win_data_q   <= 1'b0;
            hold_addr_q  <= '0;
            hold_we_q    <= 1'b0;
            hold_wdata_q <= '0;
            mreq_q       <= 1'b0;
            mwe_q        <= 1'b0;
            maddr_q      <= '0;
            mwdata_q     <= '0;
            iready_q     <= 1'b0;
            dready_q     <= 1'b0;
            irdata_q     <= '0;
            drdata_q     <= '0;
        end else begin
            state_q      <= state_d;
            fair_cnt_q   <= fair_cnt_d;
            win_data_q   <= win_data_d;
            hold_addr_q  <= hold_addr_d;
            hold_we_q    <= hold_we_d;
            hold_wdata_q <= hold_wdata_d;
            mreq_q       <= mreq_d;
            mwe_q        <= mwe_d;
            maddr_q      <= maddr_d;
            mwdata_q     <= mwdata_d;
            iready_q     <= iready_d;
            dready_q     <= dready_d;
            irdata_q     <= irdata_d;
            drdata_q     <= drdata_d;
        end
    end

    assign mreq   = mreq_q;
    assign mwe    = mwe_q;
    assign maddr  = maddr_q;
    assign mwdata = mwdata_q;
    assign iready = iready_q;
    assign dready = dready_q;
    assign irdata = irdata_q;
    assign drdata = drdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus randomized traffic,
// checked against an access-level model of the arbiter and a memory array.
module tb_mem_port_arbiter;

    localparam int FAIR_LIMIT = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        ireq, dreq, dwe, mack;
    logic [31:0] iaddr, daddr, dwdata, mrdata;
    logic [31:0] irdata, drdata, maddr, mwdata;
    logic        iready, dready, mreq, mwe;

    mem_port_arbiter #(.FAIR_LIMIT(FAIR_LIMIT)) dut (
        .clk(clk), .reset(reset),
        .ireq(ireq), .iaddr(iaddr), .irdata(irdata), .iready(iready),
        .dreq(dreq), .dwe(dwe), .daddr(daddr), .dwdata(dwdata),
        .drdata(drdata), .dready(dready),
        .mreq(mreq), .mwe(mwe), .maddr(maddr), .mwdata(mwdata),
        .mrdata(mrdata), .mack(mack)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Memory contents; unwritten words return an address-derived pattern
    logic [31:0] mem [logic [31:0]];

    // Requester state
    bit          i_pend, d_pend, d_we_r;
    logic [31:0] i_addr_r, d_addr_r, d_wd_r;
    int          i_rate, d_rate, wait_min, wait_max;
    bit          spur_en;

    // Access-level model: 0 = free, 1 = access on memory port, 2 = answering
    int          phase, cnt, wait_left;
    bit          win_d, acc_we, prev_mreq;
    logic [31:0] acc_addr, acc_wd, exp_irdata, exp_drdata;
    bit          obs_grants[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return {a[15:0], 16'hC0DE};
    endfunction

    task automatic drive_reqs();
        ireq   = i_pend;
        iaddr  = i_pend ? i_addr_r : $urandom;
        dreq   = d_pend;
        dwe    = d_pend ? d_we_r : 1'($urandom_range(1));
        daddr  = d_pend ? d_addr_r : $urandom;
        dwdata = d_pend ? d_wd_r : $urandom;
    endtask

    task automatic model_reset();
        phase = 0; cnt = 0; wait_left = 0; win_d = 0; acc_we = 0;
        acc_addr = '0; acc_wd = '0; exp_irdata = '0; exp_drdata = '0;
        prev_mreq = 0; i_pend = 0; d_pend = 0;
        mack = 0; mrdata = '0;
        drive_reqs();
    endtask

    // Hold reset low for n cycles with random inputs; all outputs must stay 0
    task automatic hold_reset(input int n);
        reset = 1'b0;
        for (int k = 0; k < n; k++) begin
            ireq = 1'($urandom_range(1)); dreq = 1'($urandom_range(1));
            dwe = 1'($urandom_range(1)); mack = 1'($urandom_range(1));
            iaddr = $urandom; daddr = $urandom; dwdata = $urandom; mrdata = $urandom;
            @(posedge clk); #1;
            chk("rst_mreq", 32'(mreq), 32'd0);
            chk("rst_mwe", 32'(mwe), 32'd0);
            chk("rst_maddr", maddr, 32'd0);
            chk("rst_mwdata", mwdata, 32'd0);
            chk("rst_iready", 32'(iready), 32'd0);
            chk("rst_dready", 32'(dready), 32'd0);
            chk("rst_irdata", irdata, 32'd0);
            chk("rst_drdata", drdata, 32'd0);
        end
        model_reset();
        reset = 1'b1;
    endtask

    // One clock: advance the model across the edge, compare, then drive the next inputs
    task automatic cycle();
        logic        pi, pd, pk, s_dwe;
        logic [31:0] s_iaddr, s_daddr, s_dwdata, s_mrdata;
        pi = ireq; pd = dreq; pk = mack; s_dwe = dwe;
        s_iaddr = iaddr; s_daddr = daddr; s_dwdata = dwdata; s_mrdata = mrdata;
        @(posedge clk); #1;

        case (phase)
            0: if (pi || pd) begin
                win_d = pd && !(pi && cnt == FAIR_LIMIT);
                if (win_d) cnt = pi ? ((cnt + 1 > FAIR_LIMIT) ? FAIR_LIMIT : cnt + 1) : 0;
                else       cnt = 0;
                acc_addr = win_d ? s_daddr : s_iaddr;
                acc_we   = win_d ? s_dwe : 1'b0;
                acc_wd   = win_d ? s_dwdata : 32'd0;
                wait_left = int'($urandom_range(wait_max, wait_min));
                phase = 1;
            end
            1: if (pk) begin
                if (acc_we) mem[acc_addr] = acc_wd;
                if (win_d) exp_drdata = s_mrdata;
                else       exp_irdata = s_mrdata;
                phase = 2;
            end
            default: phase = 0;
        endcase

        chk("mreq", 32'(mreq), 32'(phase == 1));
        chk("mwe", 32'(mwe), (phase == 1) ? 32'(acc_we) : 32'd0);
        chk("maddr", maddr, (phase == 1) ? acc_addr : 32'd0);
        chk("mwdata", mwdata, (phase == 1) ? acc_wd : 32'd0);
        chk("iready", 32'(iready), 32'(phase == 2 && !win_d));
        chk("dready", 32'(dready), 32'(phase == 2 && win_d));
        chk("irdata", irdata, exp_irdata);
        chk("drdata", drdata, exp_drdata);
        chk("fair_cnt", 32'(dut.fair_cnt_q), 32'(cnt));

        if (mreq === 1'b1 && !prev_mreq) obs_grants.push_back(maddr[13]);
        prev_mreq = (mreq === 1'b1);

        // Requesters retire on their ready and may immediately issue a new request
        if (phase == 2 && !win_d) i_pend = 0;
        if (phase == 2 && win_d)  d_pend = 0;
        if (!i_pend && int'($urandom_range(99)) < i_rate) begin
            i_pend = 1; i_addr_r = 32'h1000 + 32'($urandom_range(15)) * 4;
        end
        if (!d_pend && int'($urandom_range(99)) < d_rate) begin
            d_pend = 1; d_we_r = 1'($urandom_range(1));
            d_addr_r = 32'h2000 + 32'($urandom_range(15)) * 4; d_wd_r = $urandom;
        end
        drive_reqs();

        // Memory: acknowledge after the chosen number of wait states
        if (phase == 1) begin
            if (wait_left == 0) begin
                mack = 1'b1; mrdata = acc_we ? $urandom : mem_rd(acc_addr);
            end else begin
                wait_left--; mack = 1'b0; mrdata = $urandom;
            end
        end else begin
            mack = spur_en ? 1'($urandom_range(1)) : 1'b0; mrdata = $urandom;
        end
    endtask

    initial begin
        int busy_n, rdy_n;
        logic [31:0] load_val;
        i_rate = 0; d_rate = 0; wait_min = 0; wait_max = 0; spur_en = 0;
        model_reset();

        // Reset with random inputs, then idle with no requests
        hold_reset(4);
        for (int k = 0; k < 5; k++) cycle();

        // Single fetch, zero wait states
        mem[32'h8] = 32'h0050_0113;
        i_pend = 1; i_addr_r = 32'h8; drive_reqs();
        cycle();
        chk("fetch_mreq_t1", 32'(mreq), 32'd1);
        cycle();
        chk("fetch_iready_t2", 32'(iready), 32'd1);
        chk("fetch_irdata", irdata, 32'h0050_0113);
        for (int k = 0; k < 3; k++) cycle();

        // Store with 3 wait states; inputs changed after the grant must not leak through
        d_pend = 1; d_we_r = 1; d_addr_r = 32'd100; d_wd_r = 32'd25; drive_reqs();
        wait_min = 3; wait_max = 3; busy_n = 0; rdy_n = 0;
        cycle();
        busy_n += int'(mreq === 1'b1);
        d_wd_r = 32'd99; d_addr_r = 32'd200; d_we_r = 0; drive_reqs();
        for (int k = 0; k < 8; k++) begin
            cycle();
            busy_n += int'(mreq === 1'b1);
            rdy_n  += int'(dready === 1'b1);
        end
        chk("store_busy_cycles", 32'(busy_n), 32'd4);
        chk("store_dready_pulses", 32'(rdy_n), 32'd1);

        // Load back word 100
        d_pend = 1; d_we_r = 0; d_addr_r = 32'd100; drive_reqs();
        wait_min = 1; wait_max = 1; load_val = '0;
        for (int k = 0; k < 6; k++) begin
            cycle();
            if (dready === 1'b1) load_val = drdata;
        end
        chk("load_readback", load_val, 32'd25);

        // Contention with both requesters held continuously
        hold_reset(2);
        obs_grants.delete();
        i_rate = 100; d_rate = 100; wait_min = 0; wait_max = 2;
        for (int k = 0; k < 120 && obs_grants.size() < 10; k++) cycle();
        chk("contention_grants", 32'(obs_grants.size() >= 10), 32'd1);
        for (int k = 0; k < 10 && k < obs_grants.size(); k++)
            chk($sformatf("grant_%0d_is_data", k), 32'(obs_grants[k]), 32'(k % 5 != 4));

        // Reset during BUSY, then a stray mack after release
        i_rate = 0; d_rate = 0;
        hold_reset(2);
        d_pend = 1; d_we_r = 1; d_addr_r = 32'h2040; d_wd_r = 32'hDEAD_BEEF; drive_reqs();
        wait_min = 6; wait_max = 6;
        cycle(); cycle();
        chk("midrst_mreq_before", 32'(mreq), 32'd1);
        #2 reset = 1'b0;
        #1;
        chk("midrst_mreq_async", 32'(mreq), 32'd0);
        chk("midrst_maddr_async", maddr, 32'd0);
        chk("midrst_mwe_async", 32'(mwe), 32'd0);
        model_reset();
        @(posedge clk); #1;
        reset = 1'b1;
        mack = 1'b1; mrdata = 32'h1234_5678;
        for (int k = 0; k < 4; k++) cycle();
        chk("midrst_state_idle", 32'(dut.state_q), 32'd0);

        // Spurious mack with no requests
        spur_en = 1; wait_min = 0; wait_max = 0;
        for (int k = 0; k < 12; k++) cycle();

        // Randomized traffic with wait states and spurious acks
        i_rate = 40; d_rate = 40; wait_min = 0; wait_max = 3;
        for (int k = 0; k < 800; k++) cycle();

        // Drain outstanding requests
        i_rate = 0; d_rate = 0;
        for (int k = 0; k < 30; k++) cycle();
        chk("drain_idle", 32'(i_pend || d_pend), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
